// File: rtl/sync_tx_arb_pkg.sv
// Shared definitions for the sync_tx_arb block: payload width and parameter
// defaults, the FSM state encoding, and a small index-wrap helper.
package sync_tx_arb_pkg;

    localparam int DATA_WIDTHS     = 8;
    localparam int N_REQ_DEFAULT   = 4;
    localparam int TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_FREE = 2'd3
    } state_t;

    // Next index after idx in a ring of n entries.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sync_tx_arb_rr_pick.sv
// Purely combinational round-robin picker.
// Ports:
//   elig   - eligible requesters (already masked)
//   ptr    - first index to consider; search wraps from N-1 to 0
//   onehot - one-hot winner (all zero when nothing is eligible)
//   idx    - binary index of the winner
//   any    - at least one requester is eligible
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    int j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            // Only the first eligible entry seen from ptr onward wins.
            if (!any && elig[j]) begin
                onehot[j] = 1'b1;
                idx       = IW'(j);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sync_tx_arb.sv
// Round-robin arbiter feeding a single transmitter through a v/f handshake.
// Ports:
//   clk, reset       - clock and asynchronous active-low reset
//   req, en_mask     - per-requester level request and enable
//   req_data         - packed payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   f                - transmitter busy flag (1 = handshake in progress)
//   v, gnt           - one-cycle valid strobe and one-hot grant, both in ISSUE
//   tx_data, src     - latched payload and owner index of the current transfer
//   busy             - FSM is not in IDLE
//   err              - sticky flag: transmitter never raised f within TIMEOUT cycles
module sync_tx_arb
    import sync_tx_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTHS,
    parameter int N_REQ      = N_REQ_DEFAULT,
    parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]            en_mask,
    input  logic                        f,
    output logic                        v,
    output logic [DATA_WIDTH-1:0]       tx_data,
    output logic [N_REQ-1:0]            gnt,
    output logic [$clog2(N_REQ)-1:0]    src,
    output logic                        busy,
    output logic                        err
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t                state_reg, state_next;
    logic [IW-1:0]         ptr_reg, ptr_next;
    logic [CW-1:0]         count_reg, count_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    logic [IW-1:0]         src_reg, src_next;
    logic [N_REQ-1:0]      grant_reg, grant_next;
    logic                  err_reg, err_next;

    logic [N_REQ-1:0]      elig;
    logic [N_REQ-1:0]      pick_onehot;
    logic [IW-1:0]         pick_idx;
    logic                  pick_any;
    logic [DATA_WIDTH-1:0] payload [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_payload
        assign payload[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    assign elig = req & en_mask;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .elig   (elig),
        .ptr    (ptr_reg),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            count_reg <= '0;
            data_reg  <= '0;
            src_reg   <= '0;
            grant_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            count_reg <= count_next;
            data_reg  <= data_next;
            src_reg   <= src_next;
            grant_reg <= grant_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        count_next = count_reg;
        data_next  = data_reg;
        src_next   = src_reg;
        grant_next = grant_reg;
        err_next   = err_reg;
        v          = 1'b0;
        gnt        = '0;

        case (state_reg)
            IDLE: begin
                // The winner's payload is captured here so later changes on
                // req/req_data cannot disturb the transfer in flight.
                if (!f && pick_any) begin
                    data_next  = payload[pick_idx];
                    src_next   = pick_idx;
                    grant_next = pick_onehot;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // Outputs decode from registered state only, so v/gnt cannot
                // glitch and drop immediately on an asynchronous reset.
                v          = 1'b1;
                gnt        = grant_reg;
                ptr_next   = IW'(wrap_inc(int'(src_reg), N_REQ));
                count_next = '0;
                state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (f) begin
                    state_next = WAIT_FREE;
                end else if (count_reg >= CW'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th cycle in WAIT_ACK without f.
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    count_next = (count_reg == CW'(TIMEOUT)) ? count_reg : count_reg + 1'b1;
                end
            end
            WAIT_FREE: begin
                if (!f) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign tx_data = data_reg;
    assign src     = src_reg;
    assign busy    = (state_reg != IDLE);
    assign err     = err_reg;

endmodule

// File: tb/tb_sync_tx_arb.sv
module tb_sync_tx_arb;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 12;
    localparam int DB = N * DW;

    logic          clk;
    logic          reset;
    logic [N-1:0]  req;
    logic [DB-1:0] req_data;
    logic [N-1:0]  en_mask;
    logic          f;
    logic          v;
    logic [DW-1:0] tx_data;
    logic [N-1:0]  gnt;
    logic [1:0]    src;
    logic          busy;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;
    int n_txn    = 0;

    // Reference model state: round-robin pointer and sticky error.
    int ptr_m = 0;
    bit err_m = 1'b0;

    int fair_exp [5] = '{0, 1, 2, 3, 0};
    int mask_exp [4] = '{1, 3, 1, 3};

    sync_tx_arb #(
        .DATA_WIDTH (DW),
        .N_REQ      (N),
        .TIMEOUT    (TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .en_mask  (en_mask),
        .f        (f),
        .v        (v),
        .tx_data  (tx_data),
        .gnt      (gnt),
        .src      (src),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_v"},       64'(v),       64'(0));
        check_eq({pfx, "_gnt"},     64'(gnt),     64'(0));
        check_eq({pfx, "_busy"},    64'(busy),    64'(0));
        check_eq({pfx, "_tx_data"}, 64'(tx_data), 64'(0));
        check_eq({pfx, "_src"},     64'(src),     64'(0));
        check_eq({pfx, "_err"},     64'(err),     64'(0));
    endtask

    // Entered and left at #1 after a rising edge.
    task automatic apply_reset();
        f        = 1'b0;
        req      = '0;
        en_mask  = '0;
        req_data = '0;
        #2 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk); #1;
        reset = 1'b1;
        ptr_m = 0;
        err_m = 1'b0;
    endtask

    task automatic hold_check(input int w, input logic [DW-1:0] exp_data);
        @(negedge clk);
        check_eq("hold_v",    64'(v),       64'(0));
        check_eq("hold_gnt",  64'(gnt),     64'(0));
        check_eq("hold_busy", 64'(busy),    64'(1));
        check_eq("hold_data", 64'(tx_data), 64'(exp_data));
        check_eq("hold_src",  64'(src),     64'(w));
        check_eq("hold_err",  64'(err),     64'(err_m));
        @(posedge clk); #1;
    endtask

    // One complete transfer. bp: cycles of f=1 before arbitration; d: cycles
    // before the transmitter raises f; h: cycles f stays high; to: never ack.
    task automatic do_txn(input logic [N-1:0] r, input logic [N-1:0] m, input logic [DB-1:0] data,
                          input int bp, input int d, input int h, input bit to, output int got_src);
        logic [N-1:0]  el;
        logic [N-1:0]  exp_gnt;
        logic [DW-1:0] exp_data;
        int            w;

        req      = r;
        en_mask  = m;
        req_data = data;
        el       = r & m;

        w = -1;
        for (int k = 0; k < N; k++) begin
            int jj;
            jj = (ptr_m + k) % N;
            if (w < 0 && el[jj]) w = jj;
        end
        exp_gnt    = '0;
        exp_gnt[w] = 1'b1;
        exp_data   = data[w*DW +: DW];

        f = (bp > 0);
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            check_eq("bp_v",    64'(v),    64'(0));
            check_eq("bp_gnt",  64'(gnt),  64'(0));
            check_eq("bp_busy", 64'(busy), 64'(0));
            @(posedge clk); #1;
        end
        f = 1'b0;

        @(posedge clk); #1;
        @(negedge clk);
        check_eq("issue_v",    64'(v),       64'(1));
        check_eq("issue_gnt",  64'(gnt),     64'(exp_gnt));
        check_eq("issue_data", 64'(tx_data), 64'(exp_data));
        check_eq("issue_src",  64'(src),     64'(w));
        check_eq("issue_busy", 64'(busy),    64'(1));
        got_src = int'(src);
        ptr_m   = (w + 1) % N;

        $display("txn %0d: req=%b mask=%b bp=%0d d=%0d h=%0d to=%0d -> exp src=%0d data=%h, dut src=%0d data=%h",
                 n_txn, r, m, bp, d, h, to, w, exp_data, src, tx_data);
        n_txn++;

        // Disturb every input once the grant is out; the transfer must not care.
        req      = N'($urandom);
        en_mask  = N'($urandom);
        req_data = DB'($urandom);
        @(posedge clk); #1;

        if (to) begin
            for (int k = 0; k < TO; k++) hold_check(w, exp_data);
            err_m = 1'b1;
        end else begin
            for (int k = 0; k < d; k++) hold_check(w, exp_data);
            f = 1'b1;
            for (int k = 0; k < h; k++) hold_check(w, exp_data);
            f = 1'b0;
            hold_check(w, exp_data);
        end

        // Back in IDLE; keep the arbiter quiet for one cycle.
        req = '0;
        @(negedge clk);
        check_eq("idle_busy", 64'(busy), 64'(0));
        check_eq("idle_v",    64'(v),    64'(0));
        check_eq("idle_err",  64'(err),  64'(err_m));
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int            s;
        logic [N-1:0]  r, m;
        int            bp, d, h;
        bit            to;

        reset    = 1'b1;
        f        = 1'b0;
        req      = '0;
        en_mask  = '0;
        req_data = '0;

        apply_reset();

        // Single request.
        do_txn(4'b0001, 4'b1111, 32'h112233A5, 0, 2, 1, 1'b0, s);
        check_eq("single_src", 64'(s), 64'(0));

        // Fairness with all requesters held.
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            do_txn(4'b1111, 4'b1111, DB'($urandom), 0, 3, 1, 1'b0, s);
            check_eq("fair_src", 64'(s), 64'(fair_exp[i]));
        end

        // Masked requesters are skipped.
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            do_txn(4'b1111, 4'b1010, DB'($urandom), 0, 1, 2, 1'b0, s);
            check_eq("mask_src", 64'(s), 64'(mask_exp[i]));
        end

        // Timeout; afterwards the pointer sits at 3.
        apply_reset();
        do_txn(4'b0100, 4'b1111, DB'($urandom), 0, 0, 1, 1'b1, s);
        check_eq("to_src", 64'(s), 64'(2));
        do_txn(4'b1111, 4'b1111, DB'($urandom), 0, TO - 1, 1, 1'b0, s);
        check_eq("to_next_src", 64'(s), 64'(3));

        // Back-pressure in IDLE.
        apply_reset();
        do_txn(4'b0011, 4'b1111, DB'($urandom), 3, 1, 1, 1'b0, s);
        check_eq("bp_src", 64'(s), 64'(0));

        // Asynchronous reset while in WAIT_FREE.
        apply_reset();
        req      = 4'b0001;
        en_mask  = 4'b1111;
        req_data = 32'h000000A5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        f = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("wf_busy", 64'(busy),    64'(1));
        check_eq("wf_data", 64'(tx_data), 64'(8'hA5));
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("wf_rst");
        @(posedge clk); #1;
        f     = 1'b0;
        req   = '0;
        reset = 1'b1;
        ptr_m = 0;
        err_m = 1'b0;
        do_txn(4'b1111, 4'b1111, DB'($urandom), 0, 1, 1, 1'b0, s);
        check_eq("wf_after_src", 64'(s), 64'(0));

        // Randomized traffic against the model.
        for (int t = 0; t < 60; t++) begin
            do begin
                r = N'($urandom);
                m = N'($urandom);
            end while ((r & m) == '0);
            bp = int'($urandom_range(2, 0));
            d  = int'($urandom_range(TO - 1, 0));
            h  = int'($urandom_range(4, 1));
            to = ($urandom_range(5, 0) == 0);
            do_txn(r, m, DB'($urandom), bp, d, h, to, s);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
